// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared Tuse/Tnew encodings, MD FSM states and hazard helper
// Purpose : common types for the hazard controller and its HI/LO busy tracker.
// Contents: tuse_t (0..2 = cycles until use/forwardable, 3 = unused),
//           md_state_t (IDLE/BUSY), MD_CNT_W, src_hazard() helper.
package pipe_pkg;

   typedef logic [1:0] tuse_t;

   localparam tuse_t T_UNUSED = 2'd3;

   typedef enum logic {
      MD_IDLE = 1'b0,
      MD_BUSY = 1'b1
   } md_state_t;

   localparam int MD_CNT_W = 4;

   // One source operand against the EX and MEM producers. Register $0 never
   // carries a dependency; either stage matching is enough to stall.
   function automatic logic src_hazard(
      input logic [4:0] src,
      input tuse_t      tuse,
      input logic [4:0] ex_wa,
      input tuse_t      ex_tnew,
      input logic [4:0] mem_wa,
      input tuse_t      mem_tnew
   );
      logic ex_hit;
      logic mem_hit;
      ex_hit  = (src == ex_wa)  && (ex_tnew  > tuse);
      mem_hit = (src == mem_wa) && (mem_tnew > tuse);
      return (src != 5'd0) && (tuse != T_UNUSED) && (ex_hit || mem_hit);
   endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// rtl/pipe_hazard_ctrl_if.sv - pipeline-side bus of the hazard controller
// Purpose : bundles the ID/EX/MEM hazard inputs and the stall/HI-LO outputs.
// master  : pipeline (drives ID/EX/MEM fields, observes stall and md status)
// slave   : pipe_hazard_ctrl
interface pipe_hazard_ctrl_if;
   import pipe_pkg::*;

   logic [4:0]  id_rs;
   logic [4:0]  id_rt;
   tuse_t       id_tuse_rs;
   tuse_t       id_tuse_rt;
   logic        id_is_md;
   logic [4:0]  ex_wa;
   logic [4:0]  mem_wa;
   tuse_t       ex_tnew;
   tuse_t       mem_tnew;
   logic        ex_start;
   logic        ex_md_div;

   logic        stall;
   logic        if_id_en;
   logic        md_busy;
   logic        md_done;
   logic        md_overlap;
   logic [15:0] stall_cnt;

   modport master (
      output id_rs, id_rt, id_tuse_rs, id_tuse_rt, id_is_md,
      output ex_wa, mem_wa, ex_tnew, mem_tnew, ex_start, ex_md_div,
      input  stall, if_id_en, md_busy, md_done, md_overlap, stall_cnt
   );

   modport slave (
      input  id_rs, id_rt, id_tuse_rs, id_tuse_rt, id_is_md,
      input  ex_wa, mem_wa, ex_tnew, mem_tnew, ex_start, ex_md_div,
      output stall, if_id_en, md_busy, md_done, md_overlap, stall_cnt
   );

endinterface

// File: rtl/pipe_hazard_ctrl_md_busy_tracker.sv
// rtl/pipe_hazard_ctrl_md_busy_tracker.sv - HI/LO multiply/divide busy FSM
// Purpose : tracks the multi-cycle HI/LO unit with an IDLE/BUSY FSM and a
//           down-counter loaded with MULT_CYC or DIV_CYC.
// Ports   : clk, reset (async, active-low)
//           i_start   - EX holds a mult/div this cycle
//           i_div     - qualifies i_start, 1 = div
//           o_busy    - unit computing (exactly in BUSY)
//           o_done    - one-cycle pulse after the last busy cycle
//           o_overlap - sticky: start seen while busy (not on the last cycle)
module md_busy_tracker
   import pipe_pkg::*;
#(
   parameter int MULT_CYC = 5,
   parameter int DIV_CYC  = 10
) (
   input  logic clk,
   input  logic reset,
   input  logic i_start,
   input  logic i_div,
   output logic o_busy,
   output logic o_done,
   output logic o_overlap
);

   localparam logic [MD_CNT_W-1:0] MULT_LD = MULT_CYC[MD_CNT_W-1:0];
   localparam logic [MD_CNT_W-1:0] DIV_LD  = DIV_CYC[MD_CNT_W-1:0];

   md_state_t           r_state;
   logic [MD_CNT_W-1:0] r_cnt;
   logic                r_busy;
   logic                r_done;
   logic                r_overlap;
   logic [MD_CNT_W-1:0] w_load;

   assign w_load = i_div ? DIV_LD : MULT_LD;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state   <= MD_IDLE;
         r_cnt     <= '0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_overlap <= 1'b0;
      end else begin
         r_done <= 1'b0;
         if (r_state == MD_IDLE) begin
            if (i_start) begin
               r_state <= MD_BUSY;
               r_cnt   <= w_load;
               r_busy  <= 1'b1;
            end
         end else begin
            if (r_cnt == MD_CNT_W'(1)) begin
               // Last busy cycle: the current result completes regardless,
               // and a start here chains straight into a new operation.
               r_done <= 1'b1;
               if (i_start) begin
                  r_cnt <= w_load;
               end else begin
                  r_state <= MD_IDLE;
                  r_cnt   <= '0;
                  r_busy  <= 1'b0;
               end
            end else begin
               r_cnt <= r_cnt - MD_CNT_W'(1);
               if (i_start) begin
                  r_overlap <= 1'b1;
               end
            end
         end
      end
   end

   assign o_busy    = r_busy;
   assign o_done    = r_done;
   assign o_overlap = r_overlap;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - pipeline stall/hazard controller with HI/LO tracking
// Purpose : combinational stall from Tuse/Tnew register hazards and HI/LO busy,
//           plus a saturating count of stalled cycles.
// Ports   : clk, reset (async, active-low)
//           hif (slave) - ID/EX/MEM hazard inputs; stall, if_id_en, md_busy,
//                         md_done, md_overlap, stall_cnt outputs
module pipe_hazard_ctrl
   import pipe_pkg::*;
#(
   parameter int MULT_CYC = 5,
   parameter int DIV_CYC  = 10
) (
   input  logic               clk,
   input  logic               reset,
   pipe_hazard_ctrl_if.slave  hif
);

   logic        w_rs_hz;
   logic        w_rt_hz;
   logic        w_md_hz;
   logic        w_stall;
   logic        w_md_busy;
   logic        w_md_done;
   logic        w_md_overlap;
   logic [15:0] r_stall_cnt;

   md_busy_tracker #(
      .MULT_CYC (MULT_CYC),
      .DIV_CYC  (DIV_CYC)
   ) u_md (
      .clk       (clk),
      .reset     (reset),
      .i_start   (hif.ex_start),
      .i_div     (hif.ex_md_div),
      .o_busy    (w_md_busy),
      .o_done    (w_md_done),
      .o_overlap (w_md_overlap)
   );

   assign w_rs_hz = src_hazard(hif.id_rs, hif.id_tuse_rs, hif.ex_wa, hif.ex_tnew,
                               hif.mem_wa, hif.mem_tnew);
   assign w_rt_hz = src_hazard(hif.id_rt, hif.id_tuse_rt, hif.ex_wa, hif.ex_tnew,
                               hif.mem_wa, hif.mem_tnew);

   // A start in EX occupies HI/LO from the next edge, so an HI/LO user in ID
   // must already wait this cycle.
   assign w_md_hz = hif.id_is_md & (w_md_busy | hif.ex_start);
   assign w_stall = w_rs_hz | w_rt_hz | w_md_hz;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_stall_cnt <= '0;
      end else if (w_stall && (r_stall_cnt != 16'hFFFF)) begin
         r_stall_cnt <= r_stall_cnt + 16'd1;
      end
   end

   assign hif.stall      = w_stall;
   assign hif.if_id_en   = ~w_stall;
   assign hif.md_busy    = w_md_busy;
   assign hif.md_done    = w_md_done;
   assign hif.md_overlap = w_md_overlap;
   assign hif.stall_cnt  = r_stall_cnt;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - scoreboard bench for pipe_hazard_ctrl
module tb_pipe_hazard_ctrl;
   import pipe_pkg::*;

   logic clk = 1'b0;
   logic reset;

   always #5 clk = ~clk;

   pipe_hazard_ctrl_if hif();

   pipe_hazard_ctrl #(
      .MULT_CYC (5),
      .DIV_CYC  (10)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .hif   (hif)
   );

   typedef enum {S_STALL, S_IFID, S_BUSY, S_DONE, S_OVL, S_CNT} sel_t;
   typedef struct {
      string       tag;
      sel_t        sel;
      logic [15:0] exp;
   } sb_t;

   sb_t         sb_q[$];
   int          n_vec = 0;
   int          n_err = 0;
   logic [15:0] exp_cnt = 16'd0;

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic void push(input string tag, input sel_t sel, input logic [15:0] exp);
      sb_t e;
      e.tag = tag;
      e.sel = sel;
      e.exp = exp;
      sb_q.push_back(e);
   endfunction

   task automatic drain();
      sb_t         e;
      logic [15:0] got;
      while (sb_q.size() > 0) begin
         e = sb_q.pop_front();
         case (e.sel)
            S_STALL: got = {15'd0, hif.stall};
            S_IFID:  got = {15'd0, hif.if_id_en};
            S_BUSY:  got = {15'd0, hif.md_busy};
            S_DONE:  got = {15'd0, hif.md_done};
            S_OVL:   got = {15'd0, hif.md_overlap};
            default: got = hif.stall_cnt;
         endcase
         check(e.tag, got, e.exp);
      end
   endtask

   // Inputs are set at the falling edge before calling; this pushes the
   // expected outputs, samples mid-cycle, then steps past the rising edge.
   task automatic cyc(input string tag, input logic e_stall, input logic e_busy,
                      input logic e_done, input logic e_ovl);
      push({tag, ".stall"}, S_STALL, {15'd0, e_stall});
      push({tag, ".ifid"},  S_IFID,  {15'd0, ~e_stall});
      push({tag, ".busy"},  S_BUSY,  {15'd0, e_busy});
      push({tag, ".done"},  S_DONE,  {15'd0, e_done});
      push({tag, ".ovl"},   S_OVL,   {15'd0, e_ovl});
      push({tag, ".cnt"},   S_CNT,   exp_cnt);
      #2;
      drain();
      if (e_stall && reset && exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
      @(negedge clk);
   endtask

   task automatic idle_in();
      hif.id_rs      = 5'd0;
      hif.id_rt      = 5'd0;
      hif.id_tuse_rs = T_UNUSED;
      hif.id_tuse_rt = T_UNUSED;
      hif.id_is_md   = 1'b0;
      hif.ex_wa      = 5'd0;
      hif.mem_wa     = 5'd0;
      hif.ex_tnew    = 2'd0;
      hif.mem_tnew   = 2'd0;
      hif.ex_start   = 1'b0;
      hif.ex_md_div  = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      reset = 1'b0;
      idle_in();
      @(negedge clk);
      cyc("rst", 0, 0, 0, 0);
      hif.id_rs = 5'd8; hif.id_tuse_rs = 2'd0; hif.ex_wa = 5'd8; hif.ex_tnew = 2'd1;
      cyc("rst_stall", 1, 0, 0, 0);
      reset = 1'b1;
      idle_in();
      cyc("idle", 0, 0, 0, 0);

      // register hazards
      hif.id_rs = 5'd8; hif.id_tuse_rs = 2'd0; hif.ex_wa = 5'd8; hif.ex_tnew = 2'd1;
      cyc("rs_ex", 1, 0, 0, 0);
      hif.ex_tnew = 2'd0;
      cyc("rs_ex_ready", 0, 0, 0, 0);
      hif.ex_wa = 5'd0; hif.mem_wa = 5'd8; hif.mem_tnew = 2'd2; hif.id_tuse_rs = 2'd1;
      cyc("rs_mem", 1, 0, 0, 0);
      hif.id_tuse_rs = 2'd2;
      cyc("rs_mem_eq", 0, 0, 0, 0);
      hif.id_tuse_rs = T_UNUSED; hif.mem_tnew = 2'd3;
      cyc("rs_unused", 0, 0, 0, 0);
      idle_in();
      hif.id_rt = 5'd5; hif.id_tuse_rt = 2'd1; hif.ex_wa = 5'd5; hif.ex_tnew = 2'd2;
      cyc("rt_ex", 1, 0, 0, 0);
      idle_in();
      hif.id_rt = 5'd0; hif.id_tuse_rt = 2'd0; hif.ex_wa = 5'd0; hif.ex_tnew = 2'd2;
      cyc("rt_zero", 0, 0, 0, 0);
      idle_in();
      hif.id_rs = 5'd9; hif.id_tuse_rs = 2'd0;
      hif.ex_wa = 5'd9; hif.ex_tnew = 2'd0; hif.mem_wa = 5'd9; hif.mem_tnew = 2'd1;
      cyc("both_mem", 1, 0, 0, 0);
      hif.ex_tnew = 2'd1; hif.mem_tnew = 2'd0;
      cyc("both_ex", 1, 0, 0, 0);

      // mult with an HI/LO user waiting in ID
      idle_in();
      hif.id_is_md = 1'b1; hif.ex_start = 1'b1;
      cyc("mult_start", 1, 0, 0, 0);
      hif.ex_start = 1'b0;
      for (int i = 1; i <= 5; i++) cyc("mult_busy", 1, 1, 0, 0);
      cyc("mult_done", 0, 0, 1, 0);
      hif.id_is_md = 1'b0;
      cyc("mult_after", 0, 0, 0, 0);

      // back-to-back: new start on the final busy cycle
      hif.ex_start = 1'b1;
      cyc("b2b_start", 0, 0, 0, 0);
      hif.ex_start = 1'b0;
      for (int i = 1; i <= 4; i++) cyc("b2b_busy", 0, 1, 0, 0);
      hif.ex_start = 1'b1;
      cyc("b2b_last", 0, 1, 0, 0);
      hif.ex_start = 1'b0;
      cyc("b2b_chain", 0, 1, 1, 0);
      for (int i = 7; i <= 10; i++) cyc("b2b_busy2", 0, 1, 0, 0);
      cyc("b2b_done", 0, 0, 1, 0);
      cyc("b2b_after", 0, 0, 0, 0);

      // div with an overlapping start three cycles in
      hif.ex_start = 1'b1; hif.ex_md_div = 1'b1;
      cyc("div_start", 0, 0, 0, 0);
      hif.ex_start = 1'b0; hif.ex_md_div = 1'b0;
      for (int i = 1; i <= 2; i++) cyc("div_busy", 0, 1, 0, 0);
      hif.ex_start = 1'b1;
      cyc("div_ovl_in", 0, 1, 0, 0);
      hif.ex_start = 1'b0;
      for (int i = 4; i <= 10; i++) cyc("div_busy_ovl", 0, 1, 0, 1);
      cyc("div_done", 0, 0, 1, 1);
      cyc("div_after", 0, 0, 0, 1);

      // async reset mid-division when md_cnt is 4
      hif.ex_start = 1'b1; hif.ex_md_div = 1'b1;
      cyc("abort_start", 0, 0, 0, 1);
      hif.ex_start = 1'b0; hif.ex_md_div = 1'b0;
      for (int i = 1; i <= 6; i++) cyc("abort_busy", 0, 1, 0, 1);
      #2;
      check("abort_pre_busy", {15'd0, hif.md_busy}, 16'd1);
      reset = 1'b0;
      #1;
      check("abort_busy", {15'd0, hif.md_busy}, 16'd0);
      check("abort_done", {15'd0, hif.md_done}, 16'd0);
      check("abort_ovl", {15'd0, hif.md_overlap}, 16'd0);
      check("abort_cnt", hif.stall_cnt, 16'd0);
      exp_cnt = 16'd0;
      @(negedge clk);
      cyc("abort_hold", 0, 0, 0, 0);
      reset = 1'b1;
      for (int i = 0; i < 4; i++) cyc("abort_after", 0, 0, 0, 0);

      // saturation of stall_cnt
      hif.id_rs = 5'd8; hif.id_tuse_rs = 2'd0; hif.ex_wa = 5'd8; hif.ex_tnew = 2'd1;
      repeat (65540) @(negedge clk);
      #2;
      check("sat_cnt", hif.stall_cnt, 16'hFFFF);
      check("sat_stall", {15'd0, hif.stall}, 16'd1);
      @(negedge clk);
      #2;
      check("sat_hold", hif.stall_cnt, 16'hFFFF);
      idle_in();
      @(negedge clk);
      #2;
      check("sat_idle", hif.stall_cnt, 16'hFFFF);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 Parameter MULT_CYC, default 5, gives the HI/LO busy cycles for mult/multu.
REQ-002 Parameter DIV_CYC, default 10, gives the HI/LO busy cycles for div/divu.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 id_rs, id_rt  input  5 each  source register numbers of the instruction in ID.
REQ-006 id_tuse_rs, id_tuse_rt  input  2 each  cycles until ID instruction needs the operand; 3 = not used.
REQ-007 id_is_md  input  1  ID instruction is mult/div/mfhi/mflo/mthi/mtlo.
REQ-008 ex_wa, mem_wa  input  5 each  destination register in EX and MEM; 0 = no write.
REQ-009 ex_tnew, mem_tnew  input  2 each  cycles until the EX or MEM result is forwardable.
REQ-010 ex_start  input  1  EX holds a mult/div this cycle (Start2).
REQ-011 ex_md_div  input  1  qualifies ex_start; 1 = div, 0 = mult.
REQ-012 stall  output  1  freeze PC and IF/ID, bubble ID/EX.
REQ-013 if_id_en  output  1  equals ~stall.
REQ-014 md_busy  output  1  HI/LO unit is computing.
REQ-015 md_done  output  1  one-cycle pulse at end of computation.
REQ-016 md_overlap  output  1  sticky error: ex_start seen while busy.
REQ-017 stall_cnt  output  16  count of stalled cycles.

Function
REQ-018 The block SHALL define rs_hz as (id_rs!=0) & ((id_rs==ex_wa & ex_tnew>id_tuse_rs) | (id_rs==mem_wa & mem_tnew>id_tuse_rs)).
REQ-019 The block SHALL define rt_hz like rs_hz, using id_rt and id_tuse_rt.
REQ-020 The block SHALL define md_hz as id_is_md & (md_busy | ex_start).
REQ-021 stall SHALL equal rs_hz | rt_hz | md_hz, combinationally, in the same cycle.
REQ-022 Where ex_wa and mem_wa both match a source, either matching stage SHALL be sufficient to stall.
REQ-023 The MD FSM SHALL have states IDLE and BUSY, with down-counter md_cnt[3:0].
REQ-024 IDLE with ex_start=1 at an edge: go to BUSY; md_cnt = DIV_CYC if ex_md_div=1, else MULT_CYC.
REQ-025 BUSY at an edge: md_cnt decrements; md_cnt 1->0 returns to IDLE and sets md_done=1 for exactly the next cycle.
REQ-026 md_busy SHALL be 1 exactly in BUSY, i.e. for MULT_CYC or DIV_CYC cycles after the start edge.
REQ-027 ex_start in BUSY SHALL be ignored (counter untouched) and SHALL set md_overlap, cleared only by reset.
REQ-028 ex_start on the final BUSY cycle (md_cnt=1) SHALL start a new operation; md_done still pulses.
REQ-029 stall_cnt SHALL increment on every edge with stall=1 and saturate at 16'hFFFF.

Reset
REQ-030 reset=0 SHALL immediately force IDLE, md_cnt=0, md_busy=0, md_done=0, md_overlap=0, stall_cnt=0.
REQ-031 reset mid-operation SHALL abort the operation with no md_done pulse.
REQ-032 During reset, stall SHALL still follow REQ-021 using md_busy=0.

Structure
REQ-033 The Tuse/Tnew encodings (0..3, 3 = unused) and the MD FSM state encoding SHALL live in shared package pipe_pkg.
REQ-034 The MD FSM and counter SHALL be sub-module md_busy_tracker; stall logic and stall_cnt stay in the top.

Verification
REQ-035 id_rs=8, id_tuse_rs=0, ex_wa=8, ex_tnew=1 -> stall=1, if_id_en=0; with ex_tnew=0 -> stall=0.
REQ-036 id_rt=0, ex_wa=0, ex_tnew=2, id_tuse_rt=0 -> stall=0 ($0 is never a hazard).
REQ-037 ex_start=1, ex_md_div=0 at edge 0 -> md_busy=1 for 5 cycles, md_done=1 in cycle 6 only; id_is_md=1 throughout -> stall=1 from cycle 0 to 5.
REQ-038 div start, then ex_start again 3 cycles later -> md_overlap=1, md_busy falls after 10 cycles total.
REQ-039 reset=0 asynchronously at md_cnt=4 -> md_busy=0 at once, no md_done pulse, stall_cnt=0.
REQ-040 stall held 65540 cycles -> stall_cnt=16'hFFFF.
